// File: rtl/pc_sequencer.sv
// pc_sequencer: registered fetch program counter with prioritised next-PC
// selection (trap > branch > return > jump > stall hold > sequential),
// a one-cycle redirect/flush flag and a post-reset pc_valid flag.
// Optional feature macro: RAS_EN adds a circular return-address stack
// (RAS_DEPTH entries) that calls push into and returns pop from.
module pc_sequencer #(
  parameter int unsigned      WIDTH        = 32,
  parameter int unsigned      STEP         = 1,
  parameter logic [WIDTH-1:0] RESET_VECTOR = '0,
  parameter logic [WIDTH-1:0] TRAP_VECTOR  = WIDTH'(4),
  parameter int unsigned      RAS_DEPTH    = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             stall,
  input  logic             branch_taken,
  input  logic [WIDTH-1:0] branch_target,
  input  logic             jump_en,
  input  logic             call_en,
  input  logic [WIDTH-1:0] jump_target,
  input  logic             ret_en,
  input  logic [WIDTH-1:0] ret_target,
  input  logic             trap_en,
  output logic [WIDTH-1:0] pc,
  output logic [WIDTH-1:0] pc_plus,
  output logic             redirect,
  output logic             pc_valid
);

  // Which source wins this cycle; only the winner may have side effects.
  typedef enum logic [2:0] {
    SRC_SEQ,
    SRC_HOLD,
    SRC_JUMP,
    SRC_RET,
    SRC_BRANCH,
    SRC_TRAP
  } src_e;

  src_e             src;
  logic [WIDTH-1:0] next_pc;
  logic [WIDTH-1:0] ret_addr;
  logic             is_redirect;

  assign pc_plus = pc + WIDTH'(STEP);

  // Fixed-priority source selection; stall only matters when no redirect is requested.
  always_comb begin
    src = SRC_SEQ;
    if (trap_en)           src = SRC_TRAP;
    else if (branch_taken) src = SRC_BRANCH;
    else if (ret_en)       src = SRC_RET;
    else if (jump_en)      src = SRC_JUMP;
    else if (stall)        src = SRC_HOLD;
  end

  // Next-PC mux; targets pass through unmodified.
  always_comb begin
    next_pc     = pc_plus;
    is_redirect = 1'b0;
    case (src)
      SRC_TRAP:   begin next_pc = TRAP_VECTOR;   is_redirect = 1'b1; end
      SRC_BRANCH: begin next_pc = branch_target; is_redirect = 1'b1; end
      SRC_RET:    begin next_pc = ret_addr;      is_redirect = 1'b1; end
      SRC_JUMP:   begin next_pc = jump_target;   is_redirect = 1'b1; end
      SRC_HOLD:   next_pc = pc;
      default:    next_pc = pc_plus;
    endcase
  end

  // PC, redirect flag and valid flag registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      pc       <= RESET_VECTOR;
      redirect <= 1'b0;
      pc_valid <= 1'b0;
    end else begin
      pc       <= next_pc;
      redirect <= is_redirect;
      pc_valid <= 1'b1;
    end
  end

`ifdef RAS_EN
  localparam int unsigned PTR_W = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(RAS_DEPTH + 1);

  // ras_ptr points at the next free slot; the top of stack is ras_ptr-1.
  // Pointer arithmetic wraps because RAS_DEPTH is a power of two, so a
  // push onto a full stack silently overwrites the oldest entry.
  logic [WIDTH-1:0] ras_mem [RAS_DEPTH];
  logic [PTR_W-1:0] ras_ptr;
  logic [PTR_W-1:0] top_ptr;
  logic [CNT_W-1:0] ras_count;
  logic             push;
  logic             pop;

  assign top_ptr  = ras_ptr - PTR_W'(1);
  assign push     = (src == SRC_JUMP) && call_en;
  assign pop      = (src == SRC_RET) && (ras_count != '0);
  assign ret_addr = pop ? ras_mem[top_ptr] : ret_target;

  // Stack pointer and occupancy; reset empties the stack.
  always_ff @(posedge clk) begin
    if (reset) begin
      ras_ptr   <= '0;
      ras_count <= '0;
    end else if (push) begin
      ras_ptr <= ras_ptr + PTR_W'(1);
      if (ras_count != CNT_W'(RAS_DEPTH)) ras_count <= ras_count + CNT_W'(1);
    end else if (pop) begin
      ras_ptr   <= top_ptr;
      ras_count <= ras_count - CNT_W'(1);
    end
  end

  // Stack storage; contents need no reset since occupancy gates every read.
  always_ff @(posedge clk) begin
    if (!reset && push) ras_mem[ras_ptr] <= pc_plus;
  end
`else
  // Without the stack, returns always use the register-file target and
  // a call behaves as a plain jump.
  localparam int unsigned unused_ras_depth = RAS_DEPTH;
  logic unused_call;

  assign ret_addr    = ret_target;
  assign unused_call = call_en;
`endif

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed self-checking bench for pc_sequencer. A 32-bit instance covers
// priority, stall, redirect and (with RAS_EN) stack behaviour; an 8-bit
// instance covers PC wraparound.
module tb_pc_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        stall, branch_taken, jump_en, call_en, ret_en, trap_en;
  logic [31:0] branch_target, jump_target, ret_target;
  logic [31:0] pc, pc_plus;
  logic        redirect, pc_valid;

  logic        n_branch_taken;
  logic [7:0]  n_branch_target;
  logic [7:0]  n_pc, n_pc_plus;
  logic        n_redirect, n_pc_valid;

  int checks = 0;
  int passes = 0;
  logic [31:0] exp_q[$];
  logic [31:0] exp_pc;

  // Clock generation.
  always #5 clk = ~clk;

  pc_sequencer u_dut (
    .clk(clk), .reset(reset), .stall(stall),
    .branch_taken(branch_taken), .branch_target(branch_target),
    .jump_en(jump_en), .call_en(call_en), .jump_target(jump_target),
    .ret_en(ret_en), .ret_target(ret_target), .trap_en(trap_en),
    .pc(pc), .pc_plus(pc_plus), .redirect(redirect), .pc_valid(pc_valid)
  );

  pc_sequencer #(.WIDTH(8)) u_dut8 (
    .clk(clk), .reset(reset), .stall(1'b0),
    .branch_taken(n_branch_taken), .branch_target(n_branch_target),
    .jump_en(1'b0), .call_en(1'b0), .jump_target(8'h00),
    .ret_en(1'b0), .ret_target(8'h00), .trap_en(1'b0),
    .pc(n_pc), .pc_plus(n_pc_plus), .redirect(n_redirect), .pc_valid(n_pc_valid)
  );

  // One clock edge, then settle so outputs are sampled away from the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    stall = 0; branch_taken = 0; jump_en = 0; call_en = 0; ret_en = 0; trap_en = 0;
    branch_target = '0; jump_target = '0; ret_target = '0;
    n_branch_taken = 0; n_branch_target = '0;
  endtask

  task automatic do_reset();
    clear_inputs();
    reset = 1;
    step();
    step();
    reset = 0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (pc !== 32'h0) $display("FAIL reset_pc actual=%h expected=%h", pc, 32'h0); else passes++;
    checks++; if (redirect !== 1'b0) $display("FAIL reset_redirect actual=%b expected=0", redirect); else passes++;
    checks++; if (pc_valid !== 1'b0) $display("FAIL reset_valid actual=%b expected=0", pc_valid); else passes++;
    checks++; if (pc_plus !== 32'h1) $display("FAIL reset_pc_plus actual=%h expected=1", pc_plus); else passes++;
    for (int i = 1; i <= 3; i++) begin
      step();
      checks++; if (pc !== 32'(i)) $display("FAIL seq_pc_%0d actual=%h expected=%h", i, pc, 32'(i)); else passes++;
      checks++; if (pc_valid !== 1'b1) $display("FAIL seq_valid_%0d actual=%b expected=1", i, pc_valid); else passes++;
      checks++; if (redirect !== 1'b0) $display("FAIL seq_redirect_%0d actual=%b expected=0", i, redirect); else passes++;
    end
  endtask

  task automatic test_trap_priority();
    branch_taken = 1; branch_target = 32'h7;
    step();
    clear_inputs();
    step();
    checks++; if (pc !== 32'h8) $display("FAIL trap_setup_pc actual=%h expected=8", pc); else passes++;
    trap_en = 1; branch_taken = 1; branch_target = 32'h40; stall = 1;
    jump_en = 1; call_en = 1; jump_target = 32'h77;
    step();
    clear_inputs();
    checks++; if (pc !== 32'h4) $display("FAIL trap_pc actual=%h expected=4", pc); else passes++;
    checks++; if (redirect !== 1'b1) $display("FAIL trap_redirect actual=%b expected=1", redirect); else passes++;
    step();
    checks++; if (pc !== 32'h5) $display("FAIL trap_after_pc actual=%h expected=5", pc); else passes++;
    checks++; if (redirect !== 1'b0) $display("FAIL trap_after_redirect actual=%b expected=0", redirect); else passes++;
  endtask

  task automatic test_stall();
    branch_taken = 1; branch_target = 32'h10;
    step();
    clear_inputs();
    stall = 1;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++; if (pc !== 32'h10) $display("FAIL stall_pc_%0d actual=%h expected=10", i, pc); else passes++;
      checks++; if (redirect !== 1'b0) $display("FAIL stall_redirect_%0d actual=%b expected=0", i, redirect); else passes++;
    end
    branch_taken = 1; branch_target = 32'h80;
    step();
    clear_inputs();
    checks++; if (pc !== 32'h80) $display("FAIL stall_branch_pc actual=%h expected=80", pc); else passes++;
    checks++; if (redirect !== 1'b1) $display("FAIL stall_branch_redirect actual=%b expected=1", redirect); else passes++;
  endtask

  // Ret beats jump, jump beats stall; stack is empty here so ret uses ret_target.
  task automatic test_priority();
    ret_en = 1; ret_target = 32'h300; jump_en = 1; jump_target = 32'h500; stall = 1;
    step();
    clear_inputs();
    checks++; if (pc !== 32'h300) $display("FAIL ret_over_jump actual=%h expected=300", pc); else passes++;
    jump_en = 1; jump_target = 32'h500; stall = 1;
    step();
    clear_inputs();
    checks++; if (pc !== 32'h500) $display("FAIL jump_over_stall actual=%h expected=500", pc); else passes++;
    checks++; if (pc_plus !== 32'h501) $display("FAIL jump_pc_plus actual=%h expected=501", pc_plus); else passes++;
  endtask

  task automatic test_back_to_back();
    exp_q.push_back(32'h30);
    exp_q.push_back(32'h50);
    exp_q.push_back(32'h60);
    jump_en = 1; jump_target = 32'h30;
    step();
    clear_inputs();
    branch_taken = 1; branch_target = 32'h50;
    exp_pc = exp_q.pop_front();
    checks++; if (pc !== exp_pc || redirect !== 1'b1) $display("FAIL b2b_0 actual=%h/%b expected=%h/1", pc, redirect, exp_pc); else passes++;
    step();
    clear_inputs();
    ret_en = 1; ret_target = 32'h60;
    exp_pc = exp_q.pop_front();
    checks++; if (pc !== exp_pc || redirect !== 1'b1) $display("FAIL b2b_1 actual=%h/%b expected=%h/1", pc, redirect, exp_pc); else passes++;
    step();
    clear_inputs();
    exp_pc = exp_q.pop_front();
    checks++; if (pc !== exp_pc || redirect !== 1'b1) $display("FAIL b2b_2 actual=%h/%b expected=%h/1", pc, redirect, exp_pc); else passes++;
    step();
    checks++; if (pc !== 32'h61 || redirect !== 1'b0) $display("FAIL b2b_seq actual=%h/%b expected=61/0", pc, redirect); else passes++;
  endtask

  task automatic test_wrap();
    n_branch_taken = 1; n_branch_target = 8'hFE;
    step();
    n_branch_taken = 0;
    checks++; if (n_pc !== 8'hFE || n_pc_plus !== 8'hFF) $display("FAIL wrap8_fe actual=%h/%h expected=fe/ff", n_pc, n_pc_plus); else passes++;
    step();
    checks++; if (n_pc !== 8'hFF || n_pc_plus !== 8'h00) $display("FAIL wrap8_ff actual=%h/%h expected=ff/00", n_pc, n_pc_plus); else passes++;
    step();
    checks++; if (n_pc !== 8'h00 || n_pc_plus !== 8'h01) $display("FAIL wrap8_00 actual=%h/%h expected=00/01", n_pc, n_pc_plus); else passes++;
    checks++; if (n_redirect !== 1'b0) $display("FAIL wrap8_redirect actual=%b expected=0", n_redirect); else passes++;
    branch_taken = 1; branch_target = 32'hFFFF_FFFF;
    step();
    clear_inputs();
    checks++; if (pc_plus !== 32'h0) $display("FAIL wrap32_plus actual=%h expected=0", pc_plus); else passes++;
    step();
    checks++; if (pc !== 32'h0) $display("FAIL wrap32_pc actual=%h expected=0", pc); else passes++;
  endtask

`ifdef RAS_EN
  task automatic test_ras_nested();
    do_reset();
    // Call masked by a branch must not push.
    branch_taken = 1; branch_target = 32'h20; jump_en = 1; call_en = 1; jump_target = 32'h999;
    step();
    clear_inputs();
    checks++; if (pc !== 32'h20) $display("FAIL ras_setup_pc actual=%h expected=20", pc); else passes++;
    jump_en = 1; call_en = 1; jump_target = 32'h100;
    step();
    clear_inputs();
    for (int i = 0; i < 4; i++) step();
    checks++; if (pc !== 32'h104) $display("FAIL ras_call_walk actual=%h expected=104", pc); else passes++;
    jump_en = 1; call_en = 1; jump_target = 32'h200;
    step();
    clear_inputs();
    ret_en = 1; ret_target = 32'h3FF;
    step();
    checks++; if (pc !== 32'h105 || redirect !== 1'b1) $display("FAIL ras_ret1 actual=%h/%b expected=105/1", pc, redirect); else passes++;
    step();
    checks++; if (pc !== 32'h21) $display("FAIL ras_ret2 actual=%h expected=21", pc); else passes++;
    step();
    clear_inputs();
    checks++; if (pc !== 32'h3FF) $display("FAIL ras_ret3_empty actual=%h expected=3ff", pc); else passes++;
  endtask

  task automatic test_ras_overflow();
    do_reset();
    branch_taken = 1; branch_target = 32'hA0;
    step();
    clear_inputs();
    for (int i = 1; i <= 5; i++) begin
      jump_en = 1; call_en = 1; jump_target = 32'hA0 + 32'(i) * 32'h10;
      step();
    end
    clear_inputs();
    exp_q.push_back(32'hE1);
    exp_q.push_back(32'hD1);
    exp_q.push_back(32'hC1);
    exp_q.push_back(32'hB1);
    exp_q.push_back(32'h3FF);
    ret_en = 1; ret_target = 32'h3FF;
    for (int i = 0; i < 5; i++) begin
      step();
      exp_pc = exp_q.pop_front();
      checks++; if (pc !== exp_pc) $display("FAIL ras_ovf_ret_%0d actual=%h expected=%h", i, pc, exp_pc); else passes++;
    end
    clear_inputs();
    jump_en = 1; call_en = 1; jump_target = 32'h700;
    step();
    step();
    clear_inputs();
    reset = 1;
    step();
    reset = 0; ret_en = 1; ret_target = 32'h3FF;
    step();
    clear_inputs();
    checks++; if (pc !== 32'h3FF || pc_valid !== 1'b1) $display("FAIL ras_reset_empty actual=%h/%b expected=3ff/1", pc, pc_valid); else passes++;
  endtask
`else
  task automatic test_no_ras_call();
    jump_en = 1; call_en = 1; jump_target = 32'h100;
    step();
    clear_inputs();
    checks++; if (pc !== 32'h100) $display("FAIL plain_call_pc actual=%h expected=100", pc); else passes++;
    ret_en = 1; ret_target = 32'h3FF;
    step();
    clear_inputs();
    checks++; if (pc !== 32'h3FF) $display("FAIL plain_ret_pc actual=%h expected=3ff", pc); else passes++;
  endtask
`endif

  initial begin
    clear_inputs();
    reset = 1;
    test_reset();
    test_trap_priority();
    test_stall();
    test_priority();
    test_back_to_back();
    test_wrap();
`ifdef RAS_EN
    test_ras_nested();
    test_ras_overflow();
`else
    test_no_ras_call();
`endif
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
- Next-generation program-counter unit for the single-cycle/pipelined core.
- Replaces the two-way next-PC select with a registered PC that picks among sequential, branch, jump, return and trap sources, with stall hold and a redirect/flush indication.
- Sits between the fetch stage (drives instruction memory address) and the branch/control logic in decode/execute.

Parameters:
- WIDTH, 32, PC width in bits.
- STEP, 1, sequential increment (word-addressed instruction memory).
- RESET_VECTOR, 0, PC value loaded on reset.
- TRAP_VECTOR, 4, PC value loaded on trap.
- RAS_DEPTH, 4, return-address stack entries; power of two, ≥2; used only with RAS_EN.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- stall  in  1  hold PC; ignored when any redirect is requested.
- branch_taken  in  1  redirect to branch_target.
- branch_target  in  WIDTH  branch destination.
- jump_en  in  1  redirect to jump_target.
- call_en  in  1  qualifies jump_en as call (link); ignored unless jump_en=1.
- jump_target  in  WIDTH  jump/call destination.
- ret_en  in  1  return redirect.
- ret_target  in  WIDTH  return destination from register file.
- trap_en  in  1  redirect to TRAP_VECTOR.
- pc  out  WIDTH  current fetch PC (registered).
- pc_plus  out  WIDTH  pc + STEP (combinational from pc).
- redirect  out  1  registered; 1 for the cycle in which pc holds a redirected value (flush younger stages).
- pc_valid  out  1  registered; 0 during and 1 cycle after reset, then 1.

Behaviour:
- All state updates on rising clk. Reset has priority over every other input.
- Reset values: pc=RESET_VECTOR, redirect=0, pc_valid=0, RAS empty (count=0, pointer=0).
- pc_valid goes to 1 on the first clock edge with reset=0.
- Next-PC priority, highest first:
  - trap_en → TRAP_VECTOR
  - branch_taken → branch_target
  - ret_en → return address
  - jump_en → jump_target
  - stall → hold pc
  - else pc_plus
- Latency: a request sampled at edge N is visible on pc after edge N; redirect=1 for exactly that cycle.
- redirect=0 after any hold or sequential update.
- Consecutive redirects keep redirect high on consecutive cycles.
- Stall with no redirect request: pc, redirect=0 and RAS are all unchanged.
- Redirect requested while stall=1: the redirect is taken (stall is overridden).
- Arithmetic: pc_plus = (pc + STEP) mod 2^WIDTH. At pc = 2^WIDTH−STEP, pc_plus = 0 and the sequential update wraps to 0.
- Targets are used unmodified (no alignment masking).
- Only the winning source has side effects. Example: a call masked by trap or branch performs no push.

Optional Feature:
- Macro RAS_EN.
- Defined: circular return-address stack of RAS_DEPTH entries, each WIDTH bits.
  - Winning jump_en with call_en=1 pushes pc_plus.
  - Winning ret_en with count>0 pops and redirects to the popped entry (ret_target ignored).
  - Winning ret_en with count=0 redirects to ret_target; stack unchanged.
  - Push when full overwrites the oldest entry; count stays RAS_DEPTH.
  - Push and pop cannot coincide (priority makes ret and call mutually exclusive).
  - Reset mid-operation empties the stack.
- Undefined: no stack storage. ret_en always redirects to ret_target; call_en is ignored (plain jump).

Test Plan:
- Release reset at RESET_VECTOR=0, STEP=1, no requests → pc_valid 0 then 1; pc 0,1,2,3; redirect always 0.
- At pc=8, assert trap_en, branch_taken (target 0x40) and stall together → next pc=4 (TRAP_VECTOR), redirect=1 for one cycle, then pc=5.
- Stall for 3 cycles at pc=0x10 → pc stays 0x10, redirect 0. Then branch_taken with target 0x80 while stall=1 → pc=0x80, redirect=1.
- WIDTH=8, pc=0xFF, no requests → pc=0x00, pc_plus=0x01.
- With RAS_EN:
  - Call at pc=0x20 to 0x100, then call at 0x104 to 0x200.
  - Return → pc=0x105 (ret_target 0x3FF ignored); return again → pc=0x21.
  - Third return with ret_target=0x3FF → pc=0x3FF.
- With RAS_EN, RAS_DEPTH=4:
  - Five calls from pc_plus values A..E, then four returns → E, D, C, B.
  - Fifth return → ret_target.
  - Reset mid-sequence, then a return → ret_target.
